// File: rtl/cic_pkg.sv
// Shared helpers for the programmable CIC decimator:
// width arithmetic, guard-bit minimum and rounding constant.
package cic_pkg;

    function automatic int clog2(input longint v);
        int     r;
        longint p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Minimum guard bits so the integrators cannot lose information
    function automatic int guard_min(input int n, input int rmax, input int m);
        return n * clog2(longint'(rmax) * longint'(m));
    endfunction

    function automatic longint unsigned round_const(input int w, input int wout);
        return (wout < w) ? (64'd1 << (w - wout - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: y = x - x delayed by M decimated samples.
// Delay line and result advance only on the stage strobe.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int W = 38,
    parameter int M = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stb_in,
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         stb_out
);

    logic [W-1:0] dly [M];

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            stb_out <= 1'b0;
            for (int i = 0; i < M; i++) dly[i] <= '0;
        end else begin
            stb_out <= stb_in;
            if (stb_in) begin
                y      <= x - dly[M-1];
                dly[0] <= x;
                for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_decim_prog.sv
// N-stage CIC decimator, run-time ratio, differential delay M,
// pipelined integrators and round-half-up output truncation.
module cic_decim_prog
    import cic_pkg::*;
#(
    parameter int Win  = 16,
    parameter int N    = 2,
    parameter int M    = 1,
    parameter int RMAX = 2048,
    parameter int Wg   = 22,
    parameter int Wout = 38
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Win-1:0]        i_data,
    input  logic                  val_in,
    input  logic [clog2(RMAX):0]  i_dec_ratio,
    output logic [Wout-1:0]       o_data,
    output logic                  val_out
);

    localparam int W  = Win + Wg;
    localparam int RW = clog2(RMAX) + 1;
    localparam logic [W-1:0] RND = W'(round_const(W, Wout));

    if (Wg < guard_min(N, RMAX, M)) begin : g_guard_err
        $error("cic_decim_prog: Wg too small for N, RMAX and M");
    end
    if (Wout > W) begin : g_wout_err
        $error("cic_decim_prog: Wout exceeds Win+Wg");
    end

    function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] r);
        if (r == '0) return RW'(1);
        if (r > RW'(RMAX)) return RW'(RMAX);
        return r;
    endfunction

    logic                 rst_q;
    logic [RW-1:0]        r_act;
    logic [RW-1:0]        r_eff;
    logic [RW-1:0]        cnt;
    logic                 blk_end;
    logic                 dec_stb;
    logic [W-1:0]         integ [N];
    logic [N:0][W-1:0]    comb_x;
    logic [N:0]           stb;
    logic [W-1:0]         rounded;

    // First cycle after reset release takes the requested ratio directly
    assign r_eff   = rst_q ? clamp_ratio(i_dec_ratio) : r_act;
    assign blk_end = val_in && (cnt == r_eff - RW'(1));

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            cnt     <= '0;
            r_act   <= RW'(1);
            dec_stb <= 1'b0;
            for (int k = 0; k < N; k++) integ[k] <= '0;
        end else begin
            dec_stb <= blk_end;
            if (val_in) begin
                integ[0] <= integ[0] + {{Wg{i_data[Win-1]}}, i_data};
                for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
                cnt <= blk_end ? '0 : cnt + RW'(1);
            end
            if (blk_end) r_act <= clamp_ratio(i_dec_ratio);
            else if (rst_q) r_act <= r_eff;
        end
    end

    assign comb_x[0] = integ[N-1];
    assign stb[0]    = dec_stb;

    for (genvar k = 0; k < N; k++) begin : g_comb
        cic_comb_stage #(
            .W (W),
            .M (M)
        ) u_comb (
            .clk     (clk),
            .rst     (rst),
            .stb_in  (stb[k]),
            .x       (comb_x[k]),
            .y       (comb_x[k+1]),
            .stb_out (stb[k+1])
        );
    end

    assign rounded = comb_x[N] + RND;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= '0;
            val_out <= 1'b0;
        end else begin
            val_out <= stb[N];
            if (stb[N]) o_data <= rounded[W-1 -: Wout];
        end
    end

endmodule
